// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU.
// Holds the opcode encodings used by both the controller and the execute
// stage, the execute-stage FSM state type, and the default datapath widths.
package cpu_pkg;

  localparam int CPU_WIDTH = 8;  // default operand/result width
  localparam int CPU_OPW   = 4;  // opcode width

  // Instruction opcodes. Only ADD/SUB/MUL/DIV are executed by exec_unit;
  // the rest are handled by the controller and are unsupported here.
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LDA = 4'b0100;
  localparam logic [3:0] OP_LDB = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } exec_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide core, one bit per step.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            capture a (into the low half) and b; clears the high half
//   step            advance one bit using the selected mode
//   div_mode        1 = restoring divide, 0 = shift-add multiply (used on step)
//   a, b            operands, sampled on load
//   lo_nxt, hi_nxt  working register halves as they will be after this edge
//                   (MUL: product low/high; DIV: quotient/remainder)
module muldiv_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);

  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    work_d = work_q;
    b_d    = b_q;

    // Multiply: add b into the high half when the current multiplier bit is
    // set, then shift the whole register right (carry enters at the top).
    sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? b_q : '0)};

    // Divide: shift the next dividend bit into the partial remainder and
    // try subtracting b. The partial remainder is < 2b, so bit WIDTH of the
    // difference is set exactly when the subtraction went negative.
    trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} - {1'b0, b_q};

    if (load) begin
      work_d = {{WIDTH{1'b0}}, a};
      b_d    = b;
    end else if (step) begin
      if (div_mode) begin
        if (!trial[WIDTH]) work_d = {trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        else               work_d = {work_q[2*WIDTH-2:0], 1'b0};
      end else begin
        work_d = {sum, work_q[WIDTH-1:1]};
      end
    end

    lo_nxt = work_d[WIDTH-1:0];
    hi_nxt = work_d[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      work_q <= '0;
      b_q    <= '0;
    end else begin
      work_q <= work_d;
      b_q    <= b_d;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit CPU: ADD/SUB in one cycle, MUL/DIV iteratively.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start            request, accepted when not busy (op/a_in/b_in latched)
//   op, a_in, b_in   opcode and operands
//   busy             iterative operation in progress
//   done             one-cycle completion pulse
//   result           sum / difference / low product / quotient
//   remainder        DIV remainder, 0 for other operations
//   flag_z, flag_c   zero flag; carry/borrow/MUL overflow (0 for DIV)
//   err              divide-by-zero or unsupported opcode, valid with done
module exec_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int OPW   = CPU_OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             flag_z,
  output logic             flag_c,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  exec_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             err_q, err_d;

  logic             accept;
  logic             is_add, is_sub, is_mul, is_div, div_zero;
  logic [WIDTH:0]   add_w, sub_w;
  logic             core_load, core_step;
  logic [WIDTH-1:0] core_lo, core_hi;

  // Decode and core control are kept apart from the main next-state block
  // so the core's look-ahead outputs do not feed back into their own inputs.
  assign accept    = start && (state_q != ST_CALC);
  assign is_add    = (op == OPW'(OP_ADD));
  assign is_sub    = (op == OPW'(OP_SUB));
  assign is_mul    = (op == OPW'(OP_MUL));
  assign is_div    = (op == OPW'(OP_DIV));
  assign div_zero  = (b_in == '0);
  assign core_load = accept && (is_mul || (is_div && !div_zero));
  assign core_step = (state_q == ST_CALC);

  // Bit WIDTH of the subtraction is the borrow (a_in < b_in).
  assign add_w = {1'b0, a_in} + {1'b0, b_in};
  assign sub_w = {1'b0, a_in} - {1'b0, b_in};

  muldiv_iter #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .step     (core_step),
    .div_mode (div_q),
    .a        (a_in),
    .b        (b_in),
    .lo_nxt   (core_lo),
    .hi_nxt   (core_hi)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    result_d = result_q;
    rem_d    = rem_q;
    z_d      = z_q;
    c_d      = c_q;
    err_d    = err_q;

    if (state_q == ST_CALC) begin
      // New start requests are ignored here; just count down the bits.
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        // Capture the core's post-step value on the edge entering DONE.
        state_d  = ST_DONE;
        result_d = core_lo;
        z_d      = (core_lo == '0);
        err_d    = 1'b0;
        if (div_q) begin
          rem_d = core_hi;
          c_d   = 1'b0;
        end else begin
          rem_d = '0;
          c_d   = (core_hi != '0);
        end
      end
    end else begin
      if (state_q == ST_DONE) state_d = ST_IDLE;
      if (accept) begin
        state_d = ST_DONE;
        if (is_add) begin
          result_d = add_w[WIDTH-1:0];
          rem_d    = '0;
          z_d      = (add_w[WIDTH-1:0] == '0);
          c_d      = add_w[WIDTH];
          err_d    = 1'b0;
        end else if (is_sub) begin
          result_d = sub_w[WIDTH-1:0];
          rem_d    = '0;
          z_d      = (sub_w[WIDTH-1:0] == '0);
          c_d      = sub_w[WIDTH];
          err_d    = 1'b0;
        end else if (is_mul || (is_div && !div_zero)) begin
          state_d = ST_CALC;
          cnt_d   = CNT_W'(WIDTH - 1);
          div_d   = is_div;
        end else if (is_div) begin
          // Divide by zero: saturated quotient, dividend as remainder.
          result_d = '1;
          rem_d    = a_in;
          z_d      = 1'b0;
          c_d      = 1'b0;
          err_d    = 1'b1;
        end else begin
          // Unsupported opcode leaves the visible results untouched.
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      z_q      <= z_d;
      c_q      <= c_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q == ST_CALC);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign remainder = rem_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign err       = err_q;

endmodule
